split_bus_arbiter: RTL

- Central arbiter for the serial system bus. It shares the single master-to-slave path among MASTER_COUNT master ports, such as the demo master front-ends.
- Drives the per-master bgrant and msplit signals and the master-select mux control.
- Supports split transactions: a slave can park a master, the arbiter frees the bus for other masters, and the parked master gets the bus back with priority once the slave signals completion.

---
 rtl/split_bus_arbiter_pkg.sv | 22 ++
 rtl/split_bus_arbiter_if.sv | 31 +++
 rtl/split_bus_arbiter_rr_picker.sv | 32 +++
 rtl/split_bus_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/split_bus_arbiter_pkg.sv
// Shared types and sizing helpers for the split-capable bus arbiter.
package split_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int msel_width(input int masters);
    return (masters <= 2) ? 1 : $clog2(masters);
  endfunction

  function automatic int ssel_width(input int slaves);
    return (slaves <= 2) ? 1 : $clog2(slaves);
  endfunction

  // Pointer value that makes index 0 the first candidate after reset.
  function automatic int rr_reset_ptr(input int masters);
    return masters - 1;
  endfunction

endpackage

// File: rtl/split_bus_arbiter_if.sv
// Arbitration bus: master requests, slave split controls and arbiter grants.
interface split_bus_arbiter_if
  import split_arb_pkg::*;
#(
  parameter int MASTER_COUNT = 2,
  parameter int SLAVE_COUNT  = 3
);
  localparam int MSEL_WIDTH = msel_width(MASTER_COUNT);

  logic [MASTER_COUNT-1:0] breq;
  logic [MASTER_COUNT-1:0] bgrant;
  logic [MASTER_COUNT-1:0] msplit;
  logic [MSEL_WIDTH-1:0]   msel;
  logic                    bus_busy;
  logic [SLAVE_COUNT-1:0]  split_req;
  logic [SLAVE_COUNT-1:0]  split_done;

  // Handshake: breq is a level held until the granted transfer ends; the
  // arbiter answers with a registered one-hot bgrant. split_req/split_done are
  // single-cycle pulses. master = arbiter side, slave = requesters/slaves side.
  modport master (
    input  breq, split_req, split_done,
    output bgrant, msplit, msel, bus_busy
  );

  modport slave (
    output breq, split_req, split_done,
    input  bgrant, msplit, msel, bus_busy
  );

endinterface

// File: rtl/split_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after i_ptr, with wrap.
module rr_picker
  import split_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = msel_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  int   w_cand;
  logic w_found;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    for (int i = 1; i <= N; i++) begin
      w_cand = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/split_bus_arbiter.sv
// Central bus arbiter with round-robin grants and slave-initiated split/resume.
module split_bus_arbiter
  import split_arb_pkg::*;
#(
  parameter int MASTER_COUNT = 2,
  parameter int SLAVE_COUNT  = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  split_bus_arbiter_if.master    bus,
  output state_t                 o_state
);

  localparam int MSEL_WIDTH = msel_width(MASTER_COUNT);
  localparam int SSEL_WIDTH = ssel_width(SLAVE_COUNT);
  localparam logic [MSEL_WIDTH-1:0] PTR_RST = MSEL_WIDTH'(rr_reset_ptr(MASTER_COUNT));
  localparam logic [SSEL_WIDTH-1:0] SPTR_RST = SSEL_WIDTH'(SLAVE_COUNT - 1);

  state_t                  r_state;
  logic [MASTER_COUNT-1:0] r_bgrant;
  logic [MSEL_WIDTH-1:0]   r_msel;
  logic                    r_bus_busy;
  logic [MSEL_WIDTH-1:0]   r_rr_ptr;
  logic [MASTER_COUNT-1:0] r_split_pending;
  logic [MASTER_COUNT-1:0] r_resume_ready;
  logic [SSEL_WIDTH-1:0]   r_split_slave [MASTER_COUNT];

  logic [MASTER_COUNT-1:0] w_elig, w_rr_oh, w_res_oh;
  logic [MSEL_WIDTH-1:0]   w_rr_idx, w_res_idx;
  logic [SLAVE_COUNT-1:0]  w_slave_held, w_split_cand, w_ss_oh;
  logic [SSEL_WIDTH-1:0]   w_ss_idx;
  logic                    w_any_resume;

  // Parked masters are only eligible again through resume_ready.
  assign w_elig       = (bus.breq & ~r_split_pending) | r_resume_ready;
  assign w_any_resume = |r_resume_ready;

  rr_picker #(.N(MASTER_COUNT), .IW(MSEL_WIDTH)) u_rr_pick (
    .i_req(w_elig), .i_ptr(r_rr_ptr), .o_onehot(w_rr_oh), .o_idx(w_rr_idx)
  );

  rr_picker #(.N(MASTER_COUNT), .IW(MSEL_WIDTH)) u_res_pick (
    .i_req(r_resume_ready), .i_ptr(PTR_RST), .o_onehot(w_res_oh), .o_idx(w_res_idx)
  );

  always_comb begin
    w_slave_held = '0;
    for (int m = 0; m < MASTER_COUNT; m++) begin
      if (r_split_pending[m]) w_slave_held[r_split_slave[m]] = 1'b1;
    end
  end

  // A slave already holding a parked master cannot split a second one.
  assign w_split_cand = bus.split_req & ~w_slave_held;

  rr_picker #(.N(SLAVE_COUNT), .IW(SSEL_WIDTH)) u_split_pick (
    .i_req(w_split_cand), .i_ptr(SPTR_RST), .o_onehot(w_ss_oh), .o_idx(w_ss_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state         <= IDLE;
      r_bgrant        <= '0;
      r_msel          <= '0;
      r_bus_busy      <= 1'b0;
      r_rr_ptr        <= PTR_RST;
      r_split_pending <= '0;
      r_resume_ready  <= '0;
      for (int m = 0; m < MASTER_COUNT; m++) r_split_slave[m] <= '0;
    end else begin
      for (int m = 0; m < MASTER_COUNT; m++) begin
        if (r_split_pending[m] && bus.split_done[r_split_slave[m]])
          r_resume_ready[m] <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_any_resume) begin
            r_bgrant                   <= w_res_oh;
            r_msel                     <= w_res_idx;
            r_rr_ptr                   <= w_res_idx;
            r_bus_busy                 <= 1'b1;
            r_state                    <= BUSY;
            r_resume_ready[w_res_idx]  <= 1'b0;
            r_split_pending[w_res_idx] <= 1'b0;
          end else if (|w_rr_oh) begin
            r_bgrant   <= w_rr_oh;
            r_msel     <= w_rr_idx;
            r_rr_ptr   <= w_rr_idx;
            r_bus_busy <= 1'b1;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (|w_ss_oh) begin
            r_split_pending[r_msel] <= 1'b1;
            r_split_slave[r_msel]   <= w_ss_idx;
            r_bgrant                <= '0;
            r_bus_busy              <= 1'b0;
            r_state                 <= IDLE;
          end else if (!bus.breq[r_msel]) begin
            r_bgrant   <= '0;
            r_bus_busy <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bgrant   = r_bgrant;
  assign bus.msplit   = r_split_pending;
  assign bus.msel     = r_msel;
  assign bus.bus_busy = r_bus_busy;
  assign o_state      = r_state;

endmodule
